// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline control logic.
package pipeline_pkg;

  localparam int unsigned ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;

  // Stall/flush bundle delivered to the pipeline registers.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_unit_forwarding.sv
// Execute-stage operand forwarding select for one source operand.
module forwarding_unit #(
  parameter int unsigned ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]  rs_e_i,
  input  logic [ADDR_WIDTH-1:0]  rd_m_i,
  input  logic                   reg_write_m_i,
  input  logic [ADDR_WIDTH-1:0]  rd_w_i,
  input  logic                   reg_write_w_i,
  output pipeline_pkg::fwd_sel_t fwd_sel_c_o
);
  import pipeline_pkg::*;

  logic hit_m_c;
  logic hit_w_c;

  // x0 is hard-wired zero, so a write to it never produces a bypass.
  assign hit_m_c = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i);
  assign hit_w_c = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i);

  // The younger M-stage result takes precedence over W.
  always_comb begin
    fwd_sel_c_o = FWD_REG;
    if (hit_m_c) begin
      fwd_sel_c_o = FWD_M;
    end else if (hit_w_c) begin
      fwd_sel_c_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control with a memory-wait FSM and watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int unsigned ADDR_WIDTH = pipeline_pkg::ADDR_WIDTH,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] Rs1E,
  input  logic [ADDR_WIDTH-1:0] Rs2E,
  input  logic [ADDR_WIDTH-1:0] RdE,
  input  logic                  ResultSrcE0,
  input  logic                  PCSrcE,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic                  RegWriteW,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  MemTimeout,
  output logic [31:0]           StallCycles,
  output logic [31:0]           FlushCount
);
  import pipeline_pkg::*;

  localparam int unsigned CNT_W = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] waitcnt_q, waitcnt_d;
  logic             timeout_q, timeout_d;

  logic         memstall_c;
  logic         branch_c;
  logic         load_use_c;
  hazard_ctrl_t ctrl_c;
  fwd_sel_t     fwd_a_c;
  fwd_sel_t     fwd_b_c;

  assign memstall_c = MemReqM && !MemReadyM;
  assign branch_c   = PCSrcE && !memstall_c;
  // A taken branch squashes the dependent decode instruction, so no load-use stall with it.
  assign load_use_c = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D))
                      && !PCSrcE && !memstall_c;

  forwarding_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_sel_c_o   (fwd_a_c)
  );

  forwarding_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_sel_c_o   (fwd_b_c)
  );

  // FSM state, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      waitcnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitcnt_d = waitcnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: begin
        if (memstall_c) begin
          state_d   = MEM_WAIT;
          waitcnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_d   = RUN;
          waitcnt_d = '0;
        end else begin
          if (waitcnt_q != CNT_MAX) begin
            waitcnt_d = waitcnt_q + CNT_W'(1);
          end
          if (waitcnt_d == CNT_MAX) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Priority: reset, memory stall, branch flush, load-use.
  always_comb begin
    ctrl_c = '0;
    if (rst) begin
      ctrl_c.flush_d = 1'b1;
      ctrl_c.flush_e = 1'b1;
      ctrl_c.flush_w = 1'b1;
    end else if (memstall_c) begin
      ctrl_c.stall_f = 1'b1;
      ctrl_c.stall_d = 1'b1;
      ctrl_c.stall_e = 1'b1;
      ctrl_c.stall_m = 1'b1;
      ctrl_c.flush_w = 1'b1;
    end else if (branch_c) begin
      ctrl_c.flush_d = 1'b1;
      ctrl_c.flush_e = 1'b1;
    end else if (load_use_c) begin
      ctrl_c.stall_f = 1'b1;
      ctrl_c.stall_d = 1'b1;
      ctrl_c.flush_e = 1'b1;
    end
  end

  assign StallF     = ctrl_c.stall_f;
  assign StallD     = ctrl_c.stall_d;
  assign StallE     = ctrl_c.stall_e;
  assign StallM     = ctrl_c.stall_m;
  assign FlushD     = ctrl_c.flush_d;
  assign FlushE     = ctrl_c.flush_e;
  assign FlushW     = ctrl_c.flush_w;
  assign ForwardAE  = rst ? FWD_REG : fwd_a_c;
  assign ForwardBE  = rst ? FWD_REG : fwd_b_c;
  assign MemTimeout = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Counters wrap naturally at 2^32; reset cycles are not counted as flushes.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (ctrl_c.stall_f) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (ctrl_c.flush_e) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a per-cycle reference model and literal spot checks.
module tb_hazard_unit;
  localparam int unsigned AW  = 5;
  localparam int unsigned LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [31:0]   StallCycles, FlushCount;

  int checks   = 0;
  int failures = 0;

  hazard_unit #(.ADDR_WIDTH(AW), .WAIT_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  bit          m_live = 1'b0;
  bit          m_wait = 1'b0;
  int          m_cnt  = 0;
  bit          m_to   = 1'b0;
  logic [31:0] m_sc   = '0;
  logic [31:0] m_fc   = '0;

  // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} from the priority rules.
  function automatic logic [6:0] exp_ctrl();
    if (rst)                    return 7'b0000_111;
    if (MemReqM && !MemReadyM)  return 7'b1111_001;
    if (PCSrcE)                 return 7'b0000_110;
    if (ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
    if (rst)                                  return 2'b00;
    if (RegWriteM && RdM != 0 && RdM == rs)   return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs)   return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  always @(posedge clk) begin : model
    logic [6:0] e;
    e = exp_ctrl();
    m_live = 1'b1;
    if (rst) begin
      m_wait = 1'b0; m_cnt = 0; m_to = 1'b0; m_sc = '0; m_fc = '0;
    end else begin
      if (e[6]) m_sc = m_sc + 32'd1;
      if (e[1]) m_fc = m_fc + 32'd1;
      if (!m_wait) begin
        m_wait = MemReqM && !MemReadyM;
      end else if (MemReadyM) begin
        m_wait = 1'b0;
        m_cnt  = 0;
      end else begin
        if (m_cnt < LIM) m_cnt++;
        if (m_cnt == LIM) m_to = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [6:0] e;
    if (m_live) begin
      e = exp_ctrl();
      chk("StallF", 32'(StallF), 32'(e[6]));
      chk("StallD", 32'(StallD), 32'(e[5]));
      chk("StallE", 32'(StallE), 32'(e[4]));
      chk("StallM", 32'(StallM), 32'(e[3]));
      chk("FlushD", 32'(FlushD), 32'(e[2]));
      chk("FlushE", 32'(FlushE), 32'(e[1]));
      chk("FlushW", 32'(FlushW), 32'(e[0]));
      chk("ForwardAE", 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
      chk("ForwardBE", 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
      chk("MemTimeout", 32'(MemTimeout), 32'(m_to));
      chk("StallCycles", StallCycles, exp_perf(m_sc));
      chk("FlushCount", FlushCount, exp_perf(m_fc));
    end
  end

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Reset dominates a pending miss, branch and load-use.
    MemReqM = 1'b1; PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    RdM = 5'd3; RegWriteM = 1'b1; Rs1E = 5'd3;
    settle();
    chk("rst_flushd", 32'(FlushD), 32'd1);
    chk("rst_flushw", 32'(FlushW), 32'd1);
    chk("rst_stallf", 32'(StallF), 32'd0);
    chk("rst_fwda", 32'(ForwardAE), 32'd0);
    tick();
    idle();
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_timeout", 32'(MemTimeout), 32'd0);
    chk("post_rst_flushe", 32'(FlushE), 32'd0);
    tick();

    // Load-use, then forward from M.
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    settle();
    chk("lu_stallf", 32'(StallF), 32'd1);
    chk("lu_stalld", 32'(StallD), 32'd1);
    chk("lu_flushe", 32'(FlushE), 32'd1);
    chk("lu_flushd", 32'(FlushD), 32'd0);
    tick();
    idle();
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    settle();
    chk("lu_fwda", 32'(ForwardAE), 32'd2);
    chk("lu_done_stallf", 32'(StallF), 32'd0);
    tick();

    // Forward priority and x0.
    idle();
    RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs2E = 5'd7;
    settle(); chk("fwdb_m_over_w", 32'(ForwardBE), 32'd2); tick();
    RdM = 5'd0; RdW = 5'd0; Rs2E = 5'd0;
    settle(); chk("fwdb_x0", 32'(ForwardBE), 32'd0); tick();
    RdM = 5'd3; RdW = 5'd7; Rs2E = 5'd7; Rs1E = 5'd3;
    settle(); chk("fwdb_w", 32'(ForwardBE), 32'd1); chk("fwda_m", 32'(ForwardAE), 32'd2); tick();
    RegWriteM = 1'b0; RdM = 5'd7;
    settle(); chk("fwdb_m_disabled", 32'(ForwardBE), 32'd1); tick();

    // Three-cycle memory stall.
    idle();
    MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ms_stallm", 32'(StallM), 32'd1);
      chk("ms_flushw", 32'(FlushW), 32'd1);
      tick();
    end
    MemReadyM = 1'b1;
    settle();
    chk("ms_rel_stallf", 32'(StallF), 32'd0);
    chk("ms_rel_flushw", 32'(FlushW), 32'd0);
    tick();
    idle();
    settle();
    chk("ms_state_run", 32'(dut.state_q), 32'd0);
    chk("ms_waitcnt", 32'(dut.waitcnt_q), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall", StallCycles, 32'd4);
    chk("perf_flush", FlushCount, 32'd1);
`else
    chk("perf_stall_off", StallCycles, 32'd0);
    chk("perf_flush_off", FlushCount, 32'd0);
`endif
    tick();

    // Load-use variants.
    ResultSrcE0 = 1'b1; RdE = 5'd9; Rs2D = 5'd9;
    settle(); chk("lu_rs2_stalld", 32'(StallD), 32'd1); tick();
    RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    settle(); chk("lu_x0_stallf", 32'(StallF), 32'd0); tick();
    RdE = 5'd4; Rs1D = 5'd4; PCSrcE = 1'b1;
    settle(); chk("lu_br_stallf", 32'(StallF), 32'd0); chk("lu_br_flushd", 32'(FlushD), 32'd1); tick();

    // Ready in the request cycle: no stall, no state change.
    idle();
    MemReqM = 1'b1; MemReadyM = 1'b1;
    settle(); chk("hit_stallf", 32'(StallF), 32'd0); tick();
    settle(); chk("hit_state", 32'(dut.state_q), 32'd0); tick();

    // Branch deferred across a two-cycle memory stall.
    idle();
    PCSrcE = 1'b1; MemReqM = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("brms_flushd", 32'(FlushD), 32'd0);
      chk("brms_flushe", 32'(FlushE), 32'd0);
      tick();
    end
    MemReadyM = 1'b1;
    settle();
    chk("brms_rel_flushd", 32'(FlushD), 32'd1);
    chk("brms_rel_flushe", 32'(FlushE), 32'd1);
    tick();

    // Watchdog: short wait, release, immediate re-miss must restart the count.
    idle();
    MemReqM = 1'b1;
    repeat (3) tick();
    MemReadyM = 1'b1;
    tick();
    MemReadyM = 1'b0;
    tick();
    repeat (3) tick();
    settle(); chk("wd_before", 32'(MemTimeout), 32'd0);
    tick();
    settle(); chk("wd_set", 32'(MemTimeout), 32'd1);
    repeat (2) tick();
    MemReadyM = 1'b1;
    tick();
    idle();
    tick();
    settle(); chk("wd_sticky", 32'(MemTimeout), 32'd1);

    // Reset in MEM_WAIT aborts the wait and clears the flag.
    MemReqM = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    settle();
    chk("rstw_stallf", 32'(StallF), 32'd0);
    chk("rstw_flushw", 32'(FlushW), 32'd1);
    tick();
    rst = 1'b0;
    idle();
    settle();
    chk("rstw_timeout", 32'(MemTimeout), 32'd0);
    chk("rstw_state", 32'(dut.state_q), 32'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control for the 5-stage RV32I core. It generates the stall and flush inputs consumed by the fetch, decode, execute, memory and writeback pipeline registers, and the execute-stage forwarding selects. It contains a small memory-wait state machine with a watchdog for multi-cycle data-memory accesses. It sits beside the datapath and observes register addresses and control bits from the D, E, M and W stages.

## Interface
- `ADDR_WIDTH`, default 5: register address width.
- `WAIT_LIMIT`, default 255: memory-wait cycles before the timeout flag sets.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `Rs1D`, `Rs2D` in ADDR_WIDTH: source registers of the instruction in decode.
- `Rs1E`, `Rs2E`, `RdE` in ADDR_WIDTH: source and destination registers in execute.
- `ResultSrcE0` in 1: the instruction in execute is a load.
- `PCSrcE` in 1: a branch or jump is taken in execute.
- `RdM` in ADDR_WIDTH, `RegWriteM` in 1: memory-stage destination register and write enable.
- `RdW` in ADDR_WIDTH, `RegWriteW` in 1: writeback-stage destination register and write enable.
- `MemReqM` in 1: the memory stage holds a load or store.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushW` out 1: drive the `clr` input of the corresponding pipeline register.
- `ForwardAE`, `ForwardBE` out 2: execute operand select. 00 selects the register file, 01 the W result, 10 the M ALU result.
- `MemTimeout` out 1: sticky watchdog flag.
- `StallCycles`, `FlushCount` out 32: performance counters (see Configuration).

## Operation
- States: RUN and MEM_WAIT.
- RUN → MEM_WAIT when `MemReqM & ~MemReadyM`.
- MEM_WAIT → RUN on `MemReadyM`.
- Memory stall is `MemReqM & ~MemReadyM`, evaluated in either state. While it is active:
  - `StallF`, `StallD`, `StallE` and `StallM` are 1.
  - `FlushW` is 1, so a bubble enters writeback.
  - `FlushD` and `FlushE` are 0. A branch held in execute is deferred, not lost.
- Branch flush: `PCSrcE & ~memstall` drives `FlushD=1` and `FlushE=1`.
- Load-use stall applies when `ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & ~PCSrcE & ~memstall`. It drives `StallF=1`, `StallD=1` and `FlushE=1`.
- Priority: memory stall, then branch flush, then load-use. A taken branch squashes the dependent decode instruction, so no load-use stall is raised with it.
- Forwarding, shown for A (B is identical using `Rs2E`):
  - 10 if `RegWriteM & RdM!=0 & RdM==Rs1E`.
  - else 01 if `RegWriteW & RdW!=0 & RdW==Rs1E`.
  - else 00.
  - M wins over W. x0 is never forwarded.
- Watchdog:
  - `waitcnt` increments each MEM_WAIT cycle with `MemReadyM=0` and saturates at `WAIT_LIMIT`.
  - It clears on the transition to RUN.
  - `MemTimeout` sets when `waitcnt==WAIT_LIMIT` and is cleared only by `rst`.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs and state. They take effect at the same clock edge as the pipeline registers.
- State, `waitcnt`, `MemTimeout` and the counters update on `posedge clk`.
- While `rst=1`:
  - `FlushD`, `FlushE` and `FlushW` are 1.
  - All stalls are 0 and both forward selects are 00.
  - On the next edge: state becomes RUN, `waitcnt`, `MemTimeout`, `StallCycles` and `FlushCount` become 0.
- Reset asserted during MEM_WAIT aborts the wait; reset dominates all inputs.
- `MemReadyM=1` in the same cycle as the request means no stall and no state change.
- A new miss in the cycle right after release re-enters MEM_WAIT with `waitcnt` restarting from 0.
- A deferred `PCSrcE` flushes D and E in the release cycle.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `StallCycles` increments on every cycle with `StallF=1`.
  - `FlushCount` increments on every cycle with `FlushE=1` and `rst=0`.
  - Both are 32-bit and wrap modulo 2^32.
- `HAZARD_PERF_EN` undefined: both ports remain and are tied to 0, and no counter flops are built.

## Structure
- `pipeline_pkg` holds:
  - `fwd_sel_t`: FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - `hazard_state_t`: RUN, MEM_WAIT.
  - The shared `ADDR_WIDTH` constant.
- Sub-module `forwarding_unit` is purely combinational and instantiated once per operand (A, B).

## Test plan
- **Load-use:** `ResultSrcE0=1`, `RdE=5`, `Rs1D=5` → `StallF=StallD=FlushE=1` for one cycle. The next cycle with `RdM=5`, `RegWriteM=1`, `Rs1E=5` gives `ForwardAE=10`.
- **Forward priority:** `RdM=RdW=7`, both write enables 1, `Rs2E=7` → `ForwardBE=10`. With `RdM=RdW=0` → `ForwardBE=00`.
- **Memory stall:** `MemReqM=1`, `MemReadyM=0` for 3 cycles, then 1 → all stalls and `FlushW` are 1 for exactly 3 cycles. State is RUN after release and `waitcnt=0`.
- **Branch during memory stall:** `PCSrcE=1` throughout a 2-cycle memory stall → `FlushD/E=0` during the stall, then `FlushD=FlushE=1` in the release cycle.
- **Watchdog:** with `WAIT_LIMIT=4`, `MemReadyM` held at 0 → `MemTimeout=1` after the 4th wait cycle and still 1 after release. `rst` clears it.
- **Perf counters (`HAZARD_PERF_EN`):** 3-cycle memory stall plus one load-use → `StallCycles=4`, `FlushCount=1`. Without the macro, both read 0.
